// File: rtl/sal_sched_pkg.sv
// sal_sched shared types: DDR command kinds, pin encodings
// and the read-metadata record queued for the return path.
package sal_sched_pkg;

  typedef enum logic [2:0] {
    CMD_NOP,
    CMD_ACT,
    CMD_RD,
    CMD_WR,
    CMD_PRE,
    CMD_REF
  } cmd_e;

  // {ras_n, cas_n, we_n} with cs_n low
  localparam logic [2:0] ENC_NOP = 3'b111;
  localparam logic [2:0] ENC_ACT = 3'b011;
  localparam logic [2:0] ENC_RD  = 3'b101;
  localparam logic [2:0] ENC_WR  = 3'b100;
  localparam logic [2:0] ENC_PRE = 3'b010;
  localparam logic [2:0] ENC_REF = 3'b001;

  localparam int ID_W  = 4;
  localparam int LEN_W = 4;

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [LEN_W-1:0] len;
  } rd_meta_t;

  function automatic logic [2:0] cmd_enc(cmd_e c);
    logic [2:0] e;
    unique case (c)
      CMD_ACT: e = ENC_ACT;
      CMD_RD:  e = ENC_RD;
      CMD_WR:  e = ENC_WR;
      CMD_PRE: e = ENC_PRE;
      CMD_REF: e = ENC_REF;
      default: e = ENC_NOP;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/sal_sched_if.sv
// Read-metadata return path: scheduler (master) offers {id,len},
// read-data path (slave) pops with ready.
interface sal_sched_if #(
  parameter int ID_WIDTH  = 4,
  parameter int LEN_WIDTH = 4
);
  logic                 rd_info_valid;
  logic                 rd_info_ready;
  logic [ID_WIDTH-1:0]  rd_info_id;
  logic [LEN_WIDTH-1:0] rd_info_len;
  logic                 rd_q_full;

  modport master (
    output rd_info_valid,
    output rd_info_id,
    output rd_info_len,
    output rd_q_full,
    input  rd_info_ready
  );

  modport slave (
    input  rd_info_valid,
    input  rd_info_id,
    input  rd_info_len,
    input  rd_q_full,
    output rd_info_ready
  );
endinterface

// File: rtl/sal_rr_arbiter.sv
// N-way round-robin arbiter; search starts at ptr_i+1 and
// wraps, first requester found gets the one-hot grant.
module sal_rr_arbiter #(
  parameter int N  = 8,
  parameter int PW = 3
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o
);

  logic          hit;
  logic [PW-1:0] idx;

  always_comb begin
    gnt_o = '0;
    hit   = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = PW'((int'(ptr_i) + 1 + i) % N);
      if (!hit && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        hit        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sal_sched.sv
// Per-bank command scheduler: class-priority round-robin grant,
// registered DDR command bus and in-order read-metadata FIFO.
module sal_sched
  import sal_sched_pkg::*;
#(
  parameter int NUM_BK     = 8,
  parameter int BA_WIDTH   = 3,
  parameter int RA_WIDTH   = 16,
  parameter int CA_WIDTH   = 10,
  parameter int ID_WIDTH   = ID_W,
  parameter int LEN_WIDTH  = LEN_W,
  parameter int RD_Q_DEPTH = 8,
  localparam int AW = (RA_WIDTH > CA_WIDTH) ? RA_WIDTH : CA_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_BK-1:0]         act_req_i,
  input  logic [NUM_BK-1:0]         rd_req_i,
  input  logic [NUM_BK-1:0]         wr_req_i,
  input  logic [NUM_BK-1:0]         pre_req_i,
  input  logic [NUM_BK-1:0]         ref_req_i,
  input  logic [NUM_BK*RA_WIDTH-1:0]  ra_i,
  input  logic [NUM_BK*CA_WIDTH-1:0]  ca_i,
  input  logic [NUM_BK*ID_WIDTH-1:0]  id_i,
  input  logic [NUM_BK*LEN_WIDTH-1:0] len_i,
  output logic [NUM_BK-1:0]         bk_gnt_o,
  output logic                      cs_n_o,
  output logic                      ras_n_o,
  output logic                      cas_n_o,
  output logic                      we_n_o,
  output logic [BA_WIDTH-1:0]       ba_o,
  output logic [AW-1:0]             addr_o,
  sal_sched_if.master               rd_if
);

  localparam int QW = $clog2(RD_Q_DEPTH);

  logic [NUM_BK-1:0]    rw_v, cls_v, arb_req, gnt;
  logic [BA_WIDTH-1:0]  ptr_q, g_idx, ba_q;
  cmd_e                 g_cmd;
  logic [RA_WIDTH-1:0]  g_ra;
  logic [CA_WIDTH-1:0]  g_ca;
  logic [ID_WIDTH-1:0]  g_id;
  logic [LEN_WIDTH-1:0] g_len;
  logic [AW-1:0]        addr_d, addr_q;
  logic [2:0]           cmd_d, cmd_q;
  logic                 cs_n_q;

  rd_meta_t             mem_q [RD_Q_DEPTH];
  logic [QW-1:0]        wp_q, rp_q;
  logic [QW:0]          cnt_q;
  logic                 q_full, q_valid, push, pop;

  assign q_full  = (cnt_q == (QW+1)'(RD_Q_DEPTH));
  assign q_valid = (cnt_q != '0);

  // A full FIFO masks only reads; writes keep their class slot
  assign rw_v = (rd_req_i & {NUM_BK{~q_full}}) | wr_req_i;

  always_comb begin
    if (|rw_v)           cls_v = rw_v;
    else if (|act_req_i) cls_v = act_req_i;
    else if (|pre_req_i) cls_v = pre_req_i;
    else                 cls_v = ref_req_i;
  end

  assign arb_req = rst_n ? cls_v : '0;

  sal_rr_arbiter #(
    .N  (NUM_BK),
    .PW (BA_WIDTH)
  ) u_arb (
    .req_i (arb_req),
    .ptr_i (ptr_q),
    .gnt_o (gnt)
  );

  assign bk_gnt_o = gnt;

  always_comb begin
    g_idx = '0;
    g_cmd = CMD_NOP;
    g_ra  = '0;
    g_ca  = '0;
    g_id  = '0;
    g_len = '0;
    for (int b = 0; b < NUM_BK; b++) begin
      if (gnt[b]) begin
        g_idx = BA_WIDTH'(b);
        g_ra  = ra_i[b*RA_WIDTH +: RA_WIDTH];
        g_ca  = ca_i[b*CA_WIDTH +: CA_WIDTH];
        g_id  = id_i[b*ID_WIDTH +: ID_WIDTH];
        g_len = len_i[b*LEN_WIDTH +: LEN_WIDTH];
        unique case (1'b1)
          rd_req_i[b]:  g_cmd = CMD_RD;
          wr_req_i[b]:  g_cmd = CMD_WR;
          act_req_i[b]: g_cmd = CMD_ACT;
          pre_req_i[b]: g_cmd = CMD_PRE;
          ref_req_i[b]: g_cmd = CMD_REF;
        endcase
      end
    end
  end

  always_comb begin
    cmd_d = cmd_enc(g_cmd);
    unique case (g_cmd)
      CMD_ACT:        addr_d = AW'(g_ra);
      CMD_RD, CMD_WR: addr_d = AW'(g_ca);
      default:        addr_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cs_n_q <= 1'b1;
      cmd_q  <= ENC_NOP;
      ba_q   <= '0;
      addr_q <= '0;
      ptr_q  <= BA_WIDTH'(NUM_BK-1);
    end else begin
      cs_n_q <= 1'b0;
      cmd_q  <= cmd_d;
      if (|gnt) begin
        ba_q   <= g_idx;
        addr_q <= addr_d;
        ptr_q  <= g_idx;
      end
    end
  end

  assign cs_n_o                    = cs_n_q;
  assign {ras_n_o, cas_n_o, we_n_o} = cmd_q;
  assign ba_o                      = ba_q;
  assign addr_o                    = addr_q;

  assign push = (g_cmd == CMD_RD);
  assign pop  = q_valid & rd_if.rd_info_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wp_q].id  <= ID_W'(g_id);
      mem_q[wp_q].len <= LEN_W'(g_len);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wp_q <= wp_q + 1'b1;
      if (pop)  rp_q <= rp_q + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign rd_if.rd_info_valid = q_valid;
  assign rd_if.rd_info_id    = ID_WIDTH'(mem_q[rp_q].id);
  assign rd_if.rd_info_len   = LEN_WIDTH'(mem_q[rp_q].len);
  assign rd_if.rd_q_full     = q_full;

  for (genvar b = 0; b < NUM_BK; b++) begin : g_one_req
    a_one_req: assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0({act_req_i[b], rd_req_i[b], wr_req_i[b],
                pre_req_i[b], ref_req_i[b]}));
  end

endmodule

// File: tb/tb_sal_sched.sv
// sal_sched bench: directed scenarios plus random traffic,
// all checked against a per-cycle behavioural model.
module tb_sal_sched;

  localparam int NB = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NB-1:0]    act_req, rd_req, wr_req, pre_req, ref_req, gnt;
  logic [NB*16-1:0] ra;
  logic [NB*10-1:0] ca;
  logic [NB*4-1:0]  idv, lenv;
  logic             cs_n, ras_n, cas_n, we_n;
  logic [2:0]       ba;
  logic [15:0]      addr;
  logic             rdy = 1'b0;

  sal_sched_if #(.ID_WIDTH(4), .LEN_WIDTH(4)) rif ();
  assign rif.rd_info_ready = rdy;

  sal_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .act_req_i (act_req),
    .rd_req_i  (rd_req),
    .wr_req_i  (wr_req),
    .pre_req_i (pre_req),
    .ref_req_i (ref_req),
    .ra_i      (ra),
    .ca_i      (ca),
    .id_i      (idv),
    .len_i     (lenv),
    .bk_gnt_o  (gnt),
    .cs_n_o    (cs_n),
    .ras_n_o   (ras_n),
    .cas_n_o   (cas_n),
    .we_n_o    (we_n),
    .ba_o      (ba),
    .addr_o    (addr),
    .rd_if     (rif)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // bank request: 0 none, 1 ACT, 2 RD, 3 WR, 4 PRE, 5 REF
  int          pend [NB];
  logic [15:0] b_ra [NB];
  logic [9:0]  b_ca [NB];
  logic [3:0]  b_id [NB];
  logic [3:0]  b_len[NB];

  int          last;
  logic [7:0]  q[$];
  logic        e_cs;
  logic [2:0]  e_cmd, e_ba;
  logic [15:0] e_addr;
  logic [NB-1:0] g_obs;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int cls(int c);
    case (c)
      2, 3:    return 0;
      1:       return 1;
      4:       return 2;
      5:       return 3;
      default: return -1;
    endcase
  endfunction

  function automatic int pick();
    for (int cl = 0; cl < 4; cl++) begin
      for (int o = 0; o < NB; o++) begin
        int b;
        b = (last + 1 + o) % NB;
        if (cls(pend[b]) == cl && !(pend[b] == 2 && q.size() == 8))
          return b;
      end
    end
    return -1;
  endfunction

  function automatic logic [2:0] enc(int c);
    case (c)
      1:       return 3'b011;
      2:       return 3'b101;
      3:       return 3'b100;
      4:       return 3'b010;
      5:       return 3'b001;
      default: return 3'b111;
    endcase
  endfunction

  task automatic drive();
    for (int b = 0; b < NB; b++) begin
      act_req[b] = (pend[b] == 1);
      rd_req[b]  = (pend[b] == 2);
      wr_req[b]  = (pend[b] == 3);
      pre_req[b] = (pend[b] == 4);
      ref_req[b] = (pend[b] == 5);
      ra[b*16 +: 16]  = b_ra[b];
      ca[b*10 +: 10]  = b_ca[b];
      idv[b*4 +: 4]   = b_id[b];
      lenv[b*4 +: 4]  = b_len[b];
    end
  endtask

  task automatic model_reset();
    last   = NB - 1;
    q.delete();
    e_cs   = 1'b1;
    e_cmd  = 3'b111;
    e_ba   = '0;
    e_addr = '0;
  endtask

  task automatic new_req(int b, int c);
    pend[b]  = c;
    b_ra[b]  = 16'($urandom);
    b_ca[b]  = 10'($urandom);
    b_id[b]  = 4'($urandom);
    b_len[b] = 4'($urandom);
  endtask

  task automatic step();
    int g;
    drive();
    #1;
    chk("cs_n", 32'(cs_n), 32'(e_cs));
    chk("cmd", 32'({ras_n, cas_n, we_n}), 32'(e_cmd));
    chk("ba", 32'(ba), 32'(e_ba));
    chk("addr", 32'(addr), 32'(e_addr));
    chk("rq_valid", 32'(rif.rd_info_valid), 32'(q.size() != 0));
    chk("rq_full", 32'(rif.rd_q_full), 32'(q.size() == 8));
    if (q.size() != 0)
      chk("rq_head", 32'({rif.rd_info_id, rif.rd_info_len}), 32'(q[0]));
    g = rst_n ? pick() : -1;
    g_obs = gnt;
    chk("gnt", 32'(gnt), (g < 0) ? 32'd0 : (32'd1 << g));
    if (!rst_n) begin
      model_reset();
    end else begin
      if (rdy && q.size() != 0) void'(q.pop_front());
      e_cs  = 1'b0;
      e_cmd = 3'b111;
      if (g >= 0) begin
        e_cmd = enc(pend[g]);
        e_ba  = 3'(g);
        last  = g;
        case (pend[g])
          1:       e_addr = b_ra[g];
          2, 3:    e_addr = {6'b0, b_ca[g]};
          default: e_addr = '0;
        endcase
        if (pend[g] == 2) q.push_back({b_id[g], b_len[g]});
        pend[g] = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int b = 0; b < NB; b++) new_req(b, 0);
    drive();
    @(posedge clk);
    #1;
    model_reset();
    step();
    rst_n = 1'b1;
    repeat (5) step();

    pend[2] = 1;
    b_ra[2] = 16'h1234;
    step();
    chk("act_gnt", 32'(g_obs), 32'h04);
    chk("act_cmd", 32'({ras_n, cas_n, we_n}), 32'b011);
    chk("act_ba", 32'(ba), 32'd2);
    chk("act_addr", 32'(addr), 32'h1234);

    pend[7] = 5;
    step();
    for (int b = 1; b < 6; b += 2) begin
      pend[b] = 2;
      b_id[b] = 4'(b);
    end
    step();
    chk("rd_gnt1", 32'(g_obs), 32'h02);
    step();
    chk("rd_gnt3", 32'(g_obs), 32'h08);
    step();
    chk("rd_gnt5", 32'(g_obs), 32'h20);
    chk("rd_cmd", 32'({ras_n, cas_n, we_n}), 32'b101);
    rdy = 1'b1;
    for (int i = 1; i < 6; i += 2) begin
      chk("rq_order", 32'(rif.rd_info_id), 32'(i));
      step();
    end
    rdy = 1'b0;

    pend[0] = 4;
    pend[6] = 3;
    step();
    chk("wr_gnt", 32'(g_obs), 32'h40);
    chk("wr_cmd", 32'({ras_n, cas_n, we_n}), 32'b100);
    chk("wr_ba", 32'(ba), 32'd6);
    step();
    chk("pre_gnt", 32'(g_obs), 32'h01);
    chk("pre_cmd", 32'({ras_n, cas_n, we_n}), 32'b010);
    chk("pre_addr", 32'(addr), 32'd0);

    for (int b = 0; b < NB; b++) new_req(b, 2);
    repeat (8) step();
    chk("q_full", 32'(rif.rd_q_full), 32'd1);
    new_req(1, 2);
    new_req(2, 3);
    step();
    chk("full_wr_gnt", 32'(g_obs), 32'h04);
    step();
    chk("masked_rd", 32'(g_obs), 32'h00);
    rdy = 1'b1;
    step();
    rdy = 1'b0;
    step();
    chk("ninth_rd", 32'(g_obs), 32'h02);

    rdy = 1'b1;
    repeat (5) step();
    rdy = 1'b0;
    new_req(0, 1);
    new_req(3, 1);
    new_req(5, 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rst_cs", 32'(cs_n), 32'd1);
    chk("rst_valid", 32'(rif.rd_info_valid), 32'd0);
    step();
    chk("rst_first", 32'(g_obs), 32'h01);

    repeat (600) begin
      for (int b = 0; b < NB; b++)
        if (pend[b] == 0 && $urandom_range(0, 2) == 0)
          new_req(b, int'($urandom_range(1, 5)));
      rdy   = 1'($urandom_range(0, 1));
      rst_n = ($urandom_range(0, 99) != 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
